// File: rtl/neuron_seq.sv
// Time-multiplexed binary-weight neuron: accumulates LANES signed pixel terms per
// cycle, then presents a saturated (optionally ReLU'd) result over valid/ready.
module neuron_seq #(
  parameter int unsigned SIZE_WORD    = 8,
  parameter int unsigned NUMBER_IMAGE = 121,
  parameter int unsigned LANES        = 11,
  parameter int unsigned OUT_W        = 2*SIZE_WORD
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [SIZE_WORD*NUMBER_IMAGE-1:0] image,
  input  logic [NUMBER_IMAGE-1:0]           weight,
  input  logic                              relu_en,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_W-1:0]                  out,
  output logic                              sat
);

  localparam int unsigned N     = NUMBER_IMAGE;
  localparam int unsigned SW    = SIZE_WORD;
  localparam int unsigned C     = (N + LANES - 1) / LANES;
  localparam int unsigned CNT_W = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned NCH   = 1 << CNT_W;
  localparam int unsigned ACC_W = SW + $clog2(N) + 1;
  localparam int unsigned EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic [CNT_W-1:0]        LAST    = CNT_W'(C - 1);
  localparam logic signed [EXT_W-1:0] MAX_EXT = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_EXT = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_hs;

  logic [SW*N-1:0]           r_image;
  logic [N-1:0]              r_weight;
  logic                      r_relu;
  logic signed [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_busy;
  logic                      r_out_valid;
  logic [OUT_W-1:0]          r_out;
  logic                      r_sat;

  logic [SW-1:0]             w_cpix [NCH][LANES];
  logic                      w_cpos [NCH][LANES];
  logic signed [ACC_W-1:0]   w_chunk;
  logic signed [ACC_W-1:0]   w_final;
  logic signed [EXT_W-1:0]   w_final_ext;
  logic [OUT_W-1:0]          w_sat_val;
  logic [OUT_W-1:0]          w_out_c;
  logic                      w_sat_c;

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign sat       = r_sat;

  // Regroup latched pixels into chunks; lanes past N are zero so they add nothing.
  for (genvar k = 0; k < NCH; k++) begin : g_chunk
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int IDX = k*LANES + l;
      if (IDX < N) begin : g_real
        assign w_cpix[k][l] = r_image[SW*IDX +: SW];
        assign w_cpos[k][l] = r_weight[N-1-IDX];
      end else begin : g_pad
        assign w_cpix[k][l] = '0;
        assign w_cpos[k][l] = 1'b0;
      end
    end
  end

  always_comb begin
    w_chunk = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (w_cpos[r_cnt][l]) w_chunk = w_chunk + ACC_W'(w_cpix[r_cnt][l]);
      else                  w_chunk = w_chunk - ACC_W'(w_cpix[r_cnt][l]);
    end
  end

  assign w_final     = r_acc + w_chunk;
  assign w_final_ext = EXT_W'(w_final);

  // Clamp to OUT_W, then ReLU; sat reports the clamp only.
  always_comb begin
    w_sat_c   = 1'b0;
    w_sat_val = w_final_ext[OUT_W-1:0];
    if (w_final_ext > MAX_EXT) begin
      w_sat_val = MAX_EXT[OUT_W-1:0];
      w_sat_c   = 1'b1;
    end else if (w_final_ext < MIN_EXT) begin
      w_sat_val = MIN_EXT[OUT_W-1:0];
      w_sat_c   = 1'b1;
    end
    w_out_c = (r_relu && w_sat_val[OUT_W-1]) ? '0 : w_sat_val;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ACCUM;
          w_accept    = 1'b1;
        end
      end
      S_ACCUM: begin
        if (r_cnt == LAST) begin
          w_state_nxt = S_DONE;
          w_last      = 1'b1;
        end
      end
      S_DONE: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = S_IDLE;
          w_hs        = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand snapshot; contents are don't-care until the first accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_image  <= image;
      r_weight <= weight;
      r_relu   <= relu_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == S_ACCUM) begin
        r_acc <= w_final;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_out       <= w_out_c;
          r_sat       <= w_sat_c;
          r_out_valid <= 1'b1;
        end
      end
      if (w_hs) r_out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/neuron_seq.md
# neuron_seq

Time-multiplexed successor to the combinational binary-weight neuron. It accepts a full image vector and a weight vector on a start pulse, then accumulates the signed pixel contributions over ceil(NUMBER_IMAGE/LANES) cycles, LANES per cycle. The result leaves through a valid/ready handshake, with selectable ReLU or saturated-linear output and a saturation flag. It sits between the image buffer and the layer output register. It trades latency for adder count, so 121-input neurons fit without a 121-wide adder tree.

## Interface
Parameters:
- SIZE_WORD, 8, width of one unsigned pixel
- NUMBER_IMAGE, 121, number of pixel/weight pairs (N)
- LANES, 11, pixels consumed per accumulate cycle (1..N)
- OUT_W, 2*SIZE_WORD, signed output width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- image  in  SIZE_WORD*N  pixel i is image[SIZE_WORD*(i+1)-1 : SIZE_WORD*i], unsigned
- weight  in  N  pixel i pairs with weight[N-1-i]; 1 = +pixel, 0 = -pixel
- relu_en  in  1  sampled with start; 1 = ReLU output, 0 = signed saturated sum
- busy  out  1  high whenever state is not IDLE
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out  out  OUT_W  result, signed two's complement
- sat  out  1  the signed sum exceeded the OUT_W range; valid with out_valid

## Operation
- C = ceil(N/LANES) chunks. Chunk k covers pixels k*LANES .. k*LANES+LANES-1. Indices ≥ N contribute 0.
- Internal accumulator width is SIZE_WORD + clog2(N) + 1, signed, so it never overflows internally.
- The chunk sum is the combinational signed sum of LANES terms, each term ±zero-extended pixel.
- FSM states: IDLE, ACCUM, DONE.
- IDLE with start=1:
  - latch image, weight and relu_en into internal registers; later input changes are ignored
  - acc←0, cnt←0, then go to ACCUM
- ACCUM, each edge:
  - acc←acc+chunk(cnt), cnt←cnt+1
  - when cnt==C-1: compute final = acc+chunk(C-1), register out and sat, set out_valid←1, go to DONE
- Output rule:
  - if final > 2^(OUT_W-1)-1: out = max, sat=1
  - if final < -2^(OUT_W-1): out = min, sat=1
  - otherwise out = final, sat=0
  - then, if relu_en and out<0: out=0. sat is unaffected by ReLU.
- DONE: hold out, sat and out_valid stable until out_valid&&out_ready. On that edge: out_valid←0, go to IDLE.
- start in ACCUM or DONE: ignored, no queuing.
- start in the same cycle as the DONE handshake: ignored. It is accepted no earlier than the next cycle in IDLE.
- C==1 (LANES≥N): one ACCUM cycle.

## Timing
- Reset values: state=IDLE, busy=0, out_valid=0, out=0, sat=0, acc=0, cnt=0.
- rst in any state aborts the operation on the next edge. No partial result is produced.
- Take the edge that accepts start as edge 0:
  - busy is high after edge 0
  - out_valid is high after edge C
  - latency is C+1 cycles from the start cycle to the first cycle out_valid is visible
- Each result drops one cycle after the handshake edge.
- Minimum start-to-start interval with out_ready tied high: C+2 cycles.
- out and sat are registered; there is no combinational path from inputs to outputs. busy is decoded from state only.

## Test plan
- N=4, LANES=2, OUT_W=16, pixels {10,20,30,40}, weight=4'b1111, relu_en=0, out_ready=1 -> out=100, sat=0. out_valid rises exactly 3 cycles after the start cycle, for one cycle.
- Same pixels, weight=4'b0000:
  - relu_en=0 -> out=-100
  - relu_en=1 -> out=0, sat=0
  - Weight order check: weight=4'b1000 (pixel0 positive) -> raw sum -80.
- Padding: N=5, LANES=2, pixels {1,2,3,4,5}, weight all 1 -> out=15. out_valid appears after edge 3 (C=3).
- Saturation: N=4, LANES=4, OUT_W=8, pixels all 255.
  - weight all 1 -> out=127, sat=1
  - weight all 0, relu_en=0 -> out=-128, sat=1
- Backpressure and protocol:
  - out_ready=0 for 5 cycles -> out and sat stable, busy=1
  - start pulses during ACCUM and DONE are ignored
  - changing image after acceptance does not alter the result
- Reset mid-ACCUM: assert rst at cnt=1 -> next cycle all outputs are at reset values. A subsequent start computes the correct result with no residue in acc.
